stack_pointer_unit: RTL and testbench

Parametrised, bounds-checked stack pointer for the CPU datapath; successor to the single-register stack pointer. Holds SP and a depth count for one stack region [STACK_BASE, STACK_LIMIT] that grows up or down. Drives either the next-free or the top-of-stack address onto the shared address bus, and latches overflow, underflow and bad-load faults in a two-state fault machine.

---
 rtl/stack_pointer_unit.sv | 128 ++++++++++++
 tb/tb_stack_pointer_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_unit.sv
// Bounds-checked stack pointer with depth tracking, shared address-bus drive,
// and a two-state fault machine for overflow, underflow and bad loads.
module stack_pointer_unit #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int STACK_BASE    = 0,
    parameter int STACK_LIMIT   = 31,
    parameter bit GROW_DOWN     = 1'b0
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     Din,
    input  logic                     Aout,
    input  logic                     Aout_top,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     ERR_CLR,
    inout  wire  [ADDRESS_WIDTH-1:0] Abus,
    output logic [ADDRESS_WIDTH-1:0] SP,
    output logic [ADDRESS_WIDTH:0]   DEPTH,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     OVF,
    output logic                     UNF,
    output logic                     BND,
    output logic                     FAULT
);

    localparam int AW = ADDRESS_WIDTH;

    localparam logic [AW-1:0] EP       = AW'(GROW_DOWN ? STACK_LIMIT : STACK_BASE);
    localparam logic [AW:0]   BASE_X   = (AW+1)'(STACK_BASE);
    localparam logic [AW:0]   LIMIT_X  = (AW+1)'(STACK_LIMIT);
    localparam logic [AW:0]   CAP      = (AW+1)'(STACK_LIMIT - STACK_BASE + 1);
    // Grow-up may load one past the limit (the full pointer); if that value
    // needs AW+1 bits it can never match a bus value, so it is excluded.
    localparam logic [AW:0]   LOAD_MAX = GROW_DOWN ? LIMIT_X : (AW+1)'(STACK_LIMIT + 1);
    localparam logic [AW-1:0] SP_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   D_ONE    = {{AW{1'b0}}, 1'b1};

    typedef enum logic {ST_NORMAL, ST_FAULT} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_sp;
    logic [AW:0]     r_depth;
    logic            r_ovf;
    logic            r_unf;
    logic            r_bnd;

    logic [AW:0]     w_abus_x;
    logic            w_load_ok;
    logic [AW:0]     w_load_depth;
    logic            w_empty;
    logic            w_full;
    logic [AW-1:0]   w_sp_push;
    logic [AW-1:0]   w_sp_pop;
    logic            w_normal;
    logic            w_do_load;
    logic            w_step;
    logic            w_ovf_evt;
    logic            w_unf_evt;
    logic            w_bnd_evt;
    logic            w_fault_evt;

    assign w_abus_x     = {1'b0, Abus};
    assign w_load_ok    = (w_abus_x >= BASE_X) && (w_abus_x <= LOAD_MAX);
    assign w_load_depth = GROW_DOWN ? (LIMIT_X - w_abus_x) : (w_abus_x - BASE_X);

    assign w_empty   = (r_depth == '0);
    assign w_full    = (r_depth == CAP);
    assign w_sp_push = GROW_DOWN ? (r_sp - SP_ONE) : (r_sp + SP_ONE);
    assign w_sp_pop  = GROW_DOWN ? (r_sp + SP_ONE) : (r_sp - SP_ONE);

    // Din outranks push/pop; push together with pop cancels out.
    assign w_normal    = (r_state == ST_NORMAL);
    assign w_do_load   = w_normal && Din;
    assign w_step      = w_normal && !Din && (push ^ pop);
    assign w_bnd_evt   = w_do_load && !w_load_ok;
    assign w_ovf_evt   = w_step && push && w_full;
    assign w_unf_evt   = w_step && pop && w_empty;
    assign w_fault_evt = w_bnd_evt || w_ovf_evt || w_unf_evt;

    // Top-of-stack is the slot one step back from the next-free pointer.
    assign Abus = Aout ? r_sp : (Aout_top ? w_sp_pop : 'z);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= ST_NORMAL;
            r_sp    <= EP;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_bnd   <= 1'b0;
        end else begin
            if (w_do_load && w_load_ok) begin
                r_sp    <= Abus;
                r_depth <= w_load_depth;
            end else if (w_step && push && !w_full) begin
                r_sp    <= w_sp_push;
                r_depth <= r_depth + D_ONE;
            end else if (w_step && pop && !w_empty) begin
                r_sp    <= w_sp_pop;
                r_depth <= r_depth - D_ONE;
            end

            // A fault detected alongside ERR_CLR still latches.
            r_ovf <= w_ovf_evt || (r_ovf && !ERR_CLR);
            r_unf <= w_unf_evt || (r_unf && !ERR_CLR);
            r_bnd <= w_bnd_evt || (r_bnd && !ERR_CLR);

            if (w_fault_evt)
                r_state <= ST_FAULT;
            else if (ERR_CLR)
                r_state <= ST_NORMAL;
        end
    end

    assign SP    = r_sp;
    assign DEPTH = r_depth;
    assign EMPTY = w_empty;
    assign FULL  = w_full;
    assign OVF   = r_ovf;
    assign UNF   = r_unf;
    assign BND   = r_bnd;
    assign FAULT = (r_state == ST_FAULT);

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Table-driven bench for stack_pointer_unit: three instances (grow-up 4..7,
// grow-down 4..7, full-range default) checked through an expected-result queue.
module tb_stack_pointer_unit;

    typedef struct packed {
        logic clr;
        logic din;
        logic aout;
        logic aout_top;
        logic push;
        logic pop;
        logic err_clr;
    } cmd_t;

    localparam logic [6:0] K_NONE = 7'b0000000;
    localparam logic [6:0] K_CLR  = 7'b1000000;
    localparam logic [6:0] K_DIN  = 7'b0100000;
    localparam logic [6:0] K_AO   = 7'b0010000;
    localparam logic [6:0] K_AT   = 7'b0001000;
    localparam logic [6:0] K_PUSH = 7'b0000100;
    localparam logic [6:0] K_POP  = 7'b0000010;
    localparam logic [6:0] K_EC   = 7'b0000001;

    // Expected flag vector: {EMPTY, FULL, OVF, UNF, BND, FAULT}
    localparam logic [5:0] F_0 = 6'b000000;
    localparam logic [5:0] F_E = 6'b100000;
    localparam logic [5:0] F_F = 6'b010000;
    localparam logic [5:0] F_O = 6'b001000;
    localparam logic [5:0] F_U = 6'b000100;
    localparam logic [5:0] F_B = 6'b000010;
    localparam logic [5:0] F_X = 6'b000001;

    typedef struct {
        int         inst;
        string      name;
        cmd_t       cmd;
        logic       drv_en;
        logic [4:0] drv;
        logic       chk_bus;
        logic [4:0] bus;
        logic [4:0] sp;
        logic [5:0] depth;
        logic [5:0] flags;
    } vec_t;

    logic       clk = 1'b0;
    cmd_t       cmd     [3];
    logic       drv_en  [3];
    logic [4:0] drv_val [3];
    wire  [4:0] abus0;
    wire  [4:0] abus1;
    wire  [4:0] abus2;

    logic [4:0] sp    [3];
    logic [5:0] depth [3];
    logic       empty [3];
    logic       full  [3];
    logic       ovf   [3];
    logic       unf   [3];
    logic       bnd   [3];
    logic       fault [3];

    int total = 0;
    int bad   = 0;

    vec_t vecs [$];
    vec_t sb   [$];

    always #5 clk = ~clk;

    assign abus0 = drv_en[0] ? drv_val[0] : 5'bz;
    assign abus1 = drv_en[1] ? drv_val[1] : 5'bz;
    assign abus2 = drv_en[2] ? drv_val[2] : 5'bz;

    stack_pointer_unit #(.ADDRESS_WIDTH(5), .STACK_BASE(4), .STACK_LIMIT(7), .GROW_DOWN(1'b0)) u_up (
        .CLK(clk), .CLR(cmd[0].clr), .Din(cmd[0].din), .Aout(cmd[0].aout),
        .Aout_top(cmd[0].aout_top), .push(cmd[0].push), .pop(cmd[0].pop),
        .ERR_CLR(cmd[0].err_clr), .Abus(abus0), .SP(sp[0]), .DEPTH(depth[0]),
        .EMPTY(empty[0]), .FULL(full[0]), .OVF(ovf[0]), .UNF(unf[0]),
        .BND(bnd[0]), .FAULT(fault[0])
    );

    stack_pointer_unit #(.ADDRESS_WIDTH(5), .STACK_BASE(4), .STACK_LIMIT(7), .GROW_DOWN(1'b1)) u_dn (
        .CLK(clk), .CLR(cmd[1].clr), .Din(cmd[1].din), .Aout(cmd[1].aout),
        .Aout_top(cmd[1].aout_top), .push(cmd[1].push), .pop(cmd[1].pop),
        .ERR_CLR(cmd[1].err_clr), .Abus(abus1), .SP(sp[1]), .DEPTH(depth[1]),
        .EMPTY(empty[1]), .FULL(full[1]), .OVF(ovf[1]), .UNF(unf[1]),
        .BND(bnd[1]), .FAULT(fault[1])
    );

    stack_pointer_unit u_def (
        .CLK(clk), .CLR(cmd[2].clr), .Din(cmd[2].din), .Aout(cmd[2].aout),
        .Aout_top(cmd[2].aout_top), .push(cmd[2].push), .pop(cmd[2].pop),
        .ERR_CLR(cmd[2].err_clr), .Abus(abus2), .SP(sp[2]), .DEPTH(depth[2]),
        .EMPTY(empty[2]), .FULL(full[2]), .OVF(ovf[2]), .UNF(unf[2]),
        .BND(bnd[2]), .FAULT(fault[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] bus_of(input int i);
        case (i)
            0:       return abus0;
            1:       return abus1;
            default: return abus2;
        endcase
    endfunction

    // Bus expectation is for the pre-edge state; sp/depth/flags are post-edge.
    function automatic void add(input int inst, input string name, input logic [6:0] c,
                                input logic den, input logic [4:0] dv,
                                input logic cb, input logic [4:0] bv,
                                input logic [4:0] esp, input logic [5:0] edep,
                                input logic [5:0] efl);
        vec_t v;
        v.inst = inst; v.name = name; v.cmd = cmd_t'(c);
        v.drv_en = den; v.drv = dv; v.chk_bus = cb; v.bus = bv;
        v.sp = esp; v.depth = edep; v.flags = efl;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        logic [5:0] got_fl;
        int i;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            cmd[k]     = cmd_t'(K_NONE);
            drv_en[k]  = 1'b0;
            drv_val[k] = 5'd0;
        end
        cmd[v.inst]     = v.cmd;
        drv_en[v.inst]  = v.drv_en;
        drv_val[v.inst] = v.drv;
        sb.push_back(v);
        #1;
        if (v.chk_bus) check({v.name, " abus"}, 32'(bus_of(v.inst)), 32'(v.bus));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        i = e.inst;
        got_fl = {empty[i], full[i], ovf[i], unf[i], bnd[i], fault[i]};
        check({e.name, " sp"},    32'(sp[i]),    32'(e.sp));
        check({e.name, " depth"}, 32'(depth[i]), 32'(e.depth));
        check({e.name, " flags{E,F,O,U,B,X}"}, 32'(got_fl), 32'(e.flags));
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            cmd[k] = cmd_t'(K_NONE); drv_en[k] = 1'b0; drv_val[k] = 5'd0;
        end

        // Grow-up, BASE=4, LIMIT=7
        add(0, "up reset",        K_CLR,         1, 5'h0a, 1, 5'h0a, 5'd4, 6'd0, F_E);
        add(0, "up idle hiz",     K_NONE,        1, 5'h15, 1, 5'h15, 5'd4, 6'd0, F_E);
        add(0, "up push1",        K_PUSH,        0, 5'd0,  0, 5'd0,  5'd5, 6'd1, F_0);
        add(0, "up push2",        K_PUSH,        0, 5'd0,  0, 5'd0,  5'd6, 6'd2, F_0);
        add(0, "up push3",        K_PUSH,        0, 5'd0,  0, 5'd0,  5'd7, 6'd3, F_0);
        add(0, "up push4",        K_PUSH,        0, 5'd0,  0, 5'd0,  5'd8, 6'd4, F_F);
        add(0, "up top@full",     K_AT,          0, 5'd0,  1, 5'd7,  5'd8, 6'd4, F_F);
        add(0, "up push5 ovf",    K_PUSH,        0, 5'd0,  0, 5'd0,  5'd8, 6'd4, F_F|F_O|F_X);
        add(0, "up pop in fault", K_POP,         0, 5'd0,  0, 5'd0,  5'd8, 6'd4, F_F|F_O|F_X);
        add(0, "up errclr",       K_EC,          0, 5'd0,  0, 5'd0,  5'd8, 6'd4, F_F);
        add(0, "up pop",          K_POP,         0, 5'd0,  0, 5'd0,  5'd7, 6'd3, F_0);
        add(0, "up din 6",        K_DIN,         1, 5'd6,  0, 5'd0,  5'd6, 6'd2, F_0);
        add(0, "up din 12 bnd",   K_DIN,         1, 5'd12, 0, 5'd0,  5'd6, 6'd2, F_B|F_X);
        add(0, "up errclr b",     K_EC,          0, 5'd0,  0, 5'd0,  5'd6, 6'd2, F_0);
        add(0, "up din5+push",    K_DIN|K_PUSH,  1, 5'd5,  0, 5'd0,  5'd5, 6'd1, F_0);
        add(0, "up din 8 full",   K_DIN,         1, 5'd8,  0, 5'd0,  5'd8, 6'd4, F_F);
        add(0, "up din 3 bnd",    K_DIN,         1, 5'd3,  0, 5'd0,  5'd8, 6'd4, F_F|F_B|F_X);
        add(0, "up din in fault", K_DIN,         1, 5'd5,  0, 5'd0,  5'd8, 6'd4, F_F|F_B|F_X);
        add(0, "up errclr c",     K_EC,          0, 5'd0,  0, 5'd0,  5'd8, 6'd4, F_F);
        add(0, "up ec+push ovf",  K_EC|K_PUSH,   0, 5'd0,  0, 5'd0,  5'd8, 6'd4, F_F|F_O|F_X);
        add(0, "up errclr d",     K_EC,          0, 5'd0,  0, 5'd0,  5'd8, 6'd4, F_F);
        add(0, "up clr+push",     K_CLR|K_PUSH,  0, 5'd0,  0, 5'd0,  5'd4, 6'd0, F_E);
        add(0, "up push+pop",     K_PUSH|K_POP,  0, 5'd0,  0, 5'd0,  5'd4, 6'd0, F_E);
        add(0, "up pop unf",      K_POP,         0, 5'd0,  0, 5'd0,  5'd4, 6'd0, F_E|F_U|F_X);
        add(0, "up ec+push flt",  K_EC|K_PUSH,   0, 5'd0,  0, 5'd0,  5'd4, 6'd0, F_E);
        add(0, "up push after",   K_PUSH,        0, 5'd0,  0, 5'd0,  5'd5, 6'd1, F_0);
        add(0, "up top+push",     K_AT|K_PUSH,   0, 5'd0,  1, 5'd4,  5'd6, 6'd2, F_0);
        add(0, "up aout+pop",     K_AO|K_POP,    0, 5'd0,  1, 5'd6,  5'd5, 6'd1, F_0);

        // Grow-down, BASE=4, LIMIT=7
        add(1, "dn reset",        K_CLR,         0, 5'd0,  0, 5'd0,  5'd7, 6'd0, F_E);
        add(1, "dn push",         K_PUSH,        0, 5'd0,  0, 5'd0,  5'd6, 6'd1, F_0);
        add(1, "dn aout",         K_AO,          0, 5'd0,  1, 5'd6,  5'd6, 6'd1, F_0);
        add(1, "dn aout_top",     K_AT,          0, 5'd0,  1, 5'd7,  5'd6, 6'd1, F_0);
        add(1, "dn pop",          K_POP,         0, 5'd0,  0, 5'd0,  5'd7, 6'd0, F_E);
        add(1, "dn pop unf",      K_POP,         0, 5'd0,  0, 5'd0,  5'd7, 6'd0, F_E|F_U|F_X);
        add(1, "dn errclr",       K_EC,          0, 5'd0,  0, 5'd0,  5'd7, 6'd0, F_E);
        add(1, "dn din 5",        K_DIN,         1, 5'd5,  0, 5'd0,  5'd5, 6'd2, F_0);
        add(1, "dn din 8 bnd",    K_DIN,         1, 5'd8,  0, 5'd0,  5'd5, 6'd2, F_B|F_X);
        add(1, "dn errclr b",     K_EC,          0, 5'd0,  0, 5'd0,  5'd5, 6'd2, F_0);
        add(1, "dn push a",       K_PUSH,        0, 5'd0,  0, 5'd0,  5'd4, 6'd3, F_0);
        add(1, "dn push b full",  K_PUSH,        0, 5'd0,  0, 5'd0,  5'd3, 6'd4, F_F);
        add(1, "dn push ovf",     K_PUSH,        0, 5'd0,  0, 5'd0,  5'd3, 6'd4, F_F|F_O|F_X);
        add(1, "dn top in fault", K_AT,          0, 5'd0,  1, 5'd4,  5'd3, 6'd4, F_F|F_O|F_X);
        add(1, "dn errclr c",     K_EC,          0, 5'd0,  0, 5'd0,  5'd3, 6'd4, F_F);
        add(1, "dn din 4",        K_DIN,         1, 5'd4,  0, 5'd0,  5'd4, 6'd3, F_0);
        add(1, "dn din 3 bnd",    K_DIN,         1, 5'd3,  0, 5'd0,  5'd4, 6'd3, F_B|F_X);
        add(1, "dn errclr d",     K_EC,          0, 5'd0,  0, 5'd0,  5'd4, 6'd3, F_0);

        // Full range, defaults AW=5, BASE=0, LIMIT=31
        add(2, "def reset",       K_CLR,         0, 5'd0,  0, 5'd0,  5'd0, 6'd0, F_E);
        for (int n = 1; n <= 32; n++)
            add(2, $sformatf("def push%0d", n), K_PUSH, 0, 5'd0, 0, 5'd0,
                5'(n), 6'(n), (n == 32) ? F_F : F_0);
        add(2, "def aout+top",    K_AO|K_AT,     0, 5'd0,  1, 5'd0,  5'd0, 6'd32, F_F);
        add(2, "def top wrap",    K_AT,          0, 5'd0,  1, 5'd31, 5'd0, 6'd32, F_F);
        add(2, "def push ovf",    K_PUSH,        0, 5'd0,  0, 5'd0,  5'd0, 6'd32, F_F|F_O|F_X);
        add(2, "def errclr",      K_EC,          0, 5'd0,  0, 5'd0,  5'd0, 6'd32, F_F);
        add(2, "def pop",         K_POP,         0, 5'd0,  0, 5'd0,  5'd31, 6'd31, F_0);

        foreach (vecs[j]) apply(vecs[j]);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
